cram_diag_loader: RTL and testbench
===================================

// Module: cram_diag_loader
// PURPOSE
//   Front-end sequencer that writes and reads CRAM microwords one 4-bit slice at a time.
//   Sits directly upstream of the CRM slice boards. It drives the CRAM address (cra adr d),
//   the slice select, the EBUS d26-29 nibble and the diag load/read function strobes,
//   and it collects readback nibbles.
//   One request covers one full word: address plus NSLICE*4 data bits.
// PARAMETERS
//   NSLICE      21  4-bit slices per microword; word width = 4*NSLICE (84)
//   ADR_W       11  CRAM address width (adr 00..10)
//   STROBE_CYC  2   cycles each diag function strobe is held asserted (>=1)
// PORTS
//   clk_h              in   1          block clock, all state on rising edge
//   mr_reset_h         in   1          synchronous reset, active high
//   req_valid          in   1          request offered
//   req_ready          out  1          request accepted when valid&ready
//   req_write          in   1          1=write word, 0=read word
//   req_adr            in   ADR_W      CRAM address
//   req_data           in   4*NSLICE   write data; slice k = bits [4k+3:4k]
//   rsp_valid          out  1          one-cycle pulse, request complete
//   rsp_data           out  4*NSLICE   read data (read; verify readback when enabled)
//   rsp_err            out  1          verify mismatch; valid with rsp_valid
//   cra_adr_d_h        out  ADR_W      CRAM address to CRM boards
//   slice_sel_h        out  5          slice being addressed (0..NSLICE-1)
//   diag_load_func_l   out  1          write strobe, active low
//   diag_read_func_l   out  1          read strobe, active low
//   ebus_d_out_h       out  4          nibble driven to EBUS d26-29
//   ebus_d_oe_h        out  1          EBUS drive enable
//   ebus_d_in_h        in   4          nibble returned by selected slice
// BEHAVIOUR
//   Reset: req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, cra_adr_d_h=0,
//     slice_sel_h=0, strobes=1, ebus_d_oe_h=0, ebus_d_out_h=0. FSM->IDLE.
//   After reset: ready=1 only in IDLE. No request is queued; the block is single-outstanding.
//   States: IDLE -> ADR -> (write: WSET -> WSTB -> WHLD) | (read: RSTB -> RSMP) -> DONE -> IDLE.
//   ADR: latch adr/data/write; drive cra_adr_d_h; 1 cycle address setup; slice=0.
//   WSET: drive ebus_d_out_h=slice nibble, oe=1, 1 cycle setup.
//   WSTB: diag_load_func_l=0 for STROBE_CYC cycles; data and oe held stable.
//   WHLD: strobe=1, data held 1 cycle. Then go to WSET for the next slice, or leave after the last slice.
//   RSTB: oe=0, diag_read_func_l=0 for STROBE_CYC cycles. Sample ebus_d_in_h on the final
//     strobe cycle into slice k of rsp_data. RSMP: strobe=1 for 1 turnaround cycle.
//   Write latency (no verify): 1+NSLICE*(STROBE_CYC+2)+1 cycles from accept to rsp_valid.
//     Read latency: 1+NSLICE*(STROBE_CYC+1)+1 cycles.
//   DONE: rsp_valid=1 for one cycle. cra_adr_d_h keeps its last value until the next accept.
//   slice_sel_h counts 0..NSLICE-1 and never wraps past NSLICE-1.
//   The two strobes are never low in the same cycle. oe=0 whenever diag_read_func_l=0.
//   Reset mid-operation: strobes deassert and oe drops at the very next edge, no response is
//     produced and the partial write is abandoned.
//   req_valid while busy is ignored (ready=0). Request fields are sampled only at accept.
// CONFIGURATION
//   CRAM_VERIFY_EN defined: after the last WHLD of a write, run a full read pass
//     (RSTB/RSMP x NSLICE) and compare each slice with the write data. rsp_data=readback;
//     rsp_err=1 if any slice differs. Write latency adds NSLICE*(STROBE_CYC+1).
//   Undefined: no readback after writes; rsp_err is tied 0 and rsp_data=0 on writes.
// STRUCTURE
//   Package cram_diag_pkg: state enum (IDLE,ADR,WSET,WSTB,WHLD,RSTB,RSMP,DONE), NSLICE/ADR_W
//     defaults, a nibble typedef, and slice_get/slice_put functions.
//   Single sub-module cram_strobe_timer: loadable down-counter of STROBE_CYC that reports last-cycle.
// TESTING
//   1 Reset held 3 cycles mid-write -> all strobes 1, oe 0, ready 1 two cycles after release, no rsp_valid.
//   2 Write adr 0o1234, data slice k = k mod 16 -> slice k accompanied by nibble k mod 16 under
//     diag_load_func_l low for exactly 2 cycles; rsp_valid at cycle 1+21*4+1=86.
//   3 Read adr 0o0007, model returns ~k&0xF per slice -> rsp_data slice k = ~k&0xF; latency 65.
//   4 req_valid held during busy with different adr -> ignored; second accept only after IDLE, new adr.
//   5 Strobe-overlap/oe checker across random write/read mix -> never both strobes low; oe=0 during reads.
//   6 CRAM_VERIFY_EN: model corrupts slice 5 -> rsp_err=1, rsp_data slice 5 shows corrupted nibble;
//     clean model -> rsp_err=0.

Source files
------------

// File: rtl/cram_diag_loader_pkg.sv
// cram_diag_pkg: FSM states, default sizes and nibble-slice helpers shared by the CRAM diag loader
package cram_diag_pkg;
    localparam int unsigned NSLICE_DEF = 21;
    localparam int unsigned ADR_W_DEF = 11;
    localparam int unsigned WORD_W = 4 * NSLICE_DEF;
    typedef logic [3:0] nibble_t;
    typedef logic [4:0] slice_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [2:0] {IDLE, ADR, WSET, WSTB, WHLD, RSTB, RSMP, DONE} state_t;
    function automatic nibble_t slice_get(input word_t w, input slice_t k);
        return w[4*k +: 4];
    endfunction
    function automatic word_t slice_put(input word_t w, input slice_t k, input nibble_t n);
        word_t r;
        r = w;
        r[4*k +: 4] = n;
        return r;
    endfunction
endpackage

// File: rtl/cram_diag_loader_strobe_timer.sv
// cram_strobe_timer: loadable down-counter flagging the final cycle of a CYC-long diag strobe
module cram_strobe_timer #(
    parameter int unsigned CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);
    localparam int unsigned CW = CYC > 1 ? $clog2(CYC) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? CW'(CYC - 1) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign last = cnt_q == '0;
endmodule

// File: rtl/cram_diag_loader.sv
// cram_diag_loader: slice-serial CRAM microword write/read sequencer; CRAM_VERIFY_EN adds a readback verify pass after writes
module cram_diag_loader
    import cram_diag_pkg::*;
#(
    parameter int unsigned NSLICE = NSLICE_DEF,
    parameter int unsigned ADR_W = ADR_W_DEF,
    parameter int unsigned STROBE_CYC = 2
) (
    input  logic                  clk_h,
    input  logic                  mr_reset_h,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADR_W-1:0]      req_adr,
    input  logic [4*NSLICE-1:0]   req_data,
    output logic                  rsp_valid,
    output logic [4*NSLICE-1:0]   rsp_data,
    output logic                  rsp_err,
    output logic [ADR_W-1:0]      cra_adr_d_h,
    output logic [4:0]            slice_sel_h,
    output logic                  diag_load_func_l,
    output logic                  diag_read_func_l,
    output logic [3:0]            ebus_d_out_h,
    output logic                  ebus_d_oe_h,
    input  logic [3:0]            ebus_d_in_h
);
    localparam int unsigned W = 4 * NSLICE;
`ifdef CRAM_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif
    localparam slice_t LAST = slice_t'(NSLICE - 1);

    state_t state_q, state_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic wr_q, wr_d, err_q, err_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic load_l_q, load_l_d, read_l_q, read_l_d, oe_q, oe_d;
    nibble_t dout_q, dout_d;
    slice_t slice_q, slice_d;
    logic t_load, t_last;

    cram_strobe_timer #(.CYC(STROBE_CYC)) u_timer (
        .clk  (clk_h),
        .rst  (mr_reset_h),
        .load (t_load),
        .last (t_last)
    );

    always_comb begin
        state_d = state_q;
        adr_d = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d = wr_q;
        err_d = err_q;
        slice_d = slice_q;
        case (state_q)
            IDLE: if (req_valid && ready_q) begin
                state_d = ADR;
                adr_d = req_adr;
                wdata_d = req_data;
                wr_d = req_write;
                rdata_d = '0;
                err_d = 1'b0;
                slice_d = '0;
            end
            ADR: state_d = wr_q ? WSET : RSTB;
            WSET: state_d = WSTB;
            WSTB: state_d = t_last ? WHLD : WSTB;
            WHLD: begin
                state_d = slice_q != LAST ? WSET : (VERIFY_EN ? RSTB : DONE);
                slice_d = slice_q != LAST ? slice_q + 5'd1 : (VERIFY_EN ? '0 : slice_q);
            end
            RSTB: if (t_last) begin
                state_d = RSMP;
                rdata_d = W'(slice_put(word_t'(rdata_q), slice_q, ebus_d_in_h));
                // Only a write's readback pass is compared; plain reads never flag an error.
                err_d = err_q | (wr_q & VERIFY_EN & (ebus_d_in_h != slice_get(word_t'(wdata_q), slice_q)));
            end
            RSMP: begin
                state_d = slice_q == LAST ? DONE : RSTB;
                slice_d = slice_q == LAST ? slice_q : slice_q + 5'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        t_load = (state_d == WSTB || state_d == RSTB) && state_d != state_q;
        ready_d = state_d == IDLE;
        rsp_valid_d = state_d == DONE;
        load_l_d = state_d != WSTB;
        read_l_d = state_d != RSTB;
        oe_d = state_d inside {WSET, WSTB, WHLD};
        dout_d = oe_d ? slice_get(word_t'(wdata_d), slice_d) : dout_q;
    end

    always_ff @(posedge clk_h) begin
        if (mr_reset_h) begin
            state_q <= IDLE;
            adr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q <= 1'b0;
            err_q <= 1'b0;
            slice_q <= '0;
            ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            load_l_q <= 1'b1;
            read_l_q <= 1'b1;
            oe_q <= 1'b0;
            dout_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q <= wr_d;
            err_q <= err_d;
            slice_q <= slice_d;
            ready_q <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            load_l_q <= load_l_d;
            read_l_q <= read_l_d;
            oe_q <= oe_d;
            dout_q <= dout_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data = rdata_q;
    assign rsp_err = err_q;
    assign cra_adr_d_h = adr_q;
    assign slice_sel_h = slice_q;
    assign diag_load_func_l = load_l_q;
    assign diag_read_func_l = read_l_q;
    assign ebus_d_out_h = dout_q;
    assign ebus_d_oe_h = oe_q;
endmodule

// File: tb/tb_cram_diag_loader.sv
// tb_cram_diag_loader: scoreboard bench with a CRM board model; define CRAM_VERIFY_EN to cover the verify build
`timescale 1ns/1ps
module tb_cram_diag_loader;
    localparam int NS = 21;
    localparam int W = 84;
`ifdef CRAM_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    localparam int WLAT = VFY ? 149 : 86;
    localparam int RLAT = 65;
    localparam logic [W-1:0] PAT_UNW = 84'hBCDEF0123456789ABCDEF;
    localparam logic [W-1:0] P2  = 84'h43210FEDCBA9876543210;
    localparam logic [W-1:0] PB  = 84'h123456789ABCDEF012345;
    localparam logic [W-1:0] DA  = 84'h0F1E2D3C4B5A69788796A;
    localparam logic [W-1:0] DB  = 84'hFFFFF00000FFFFF00000F;
    localparam logic [W-1:0] PD  = 84'hA5A5A5A5A5A5A5A5A5A5A;
    localparam logic [W-1:0] PDC = 84'hA5A5A5A5A5A5A5AAA5A5A;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           lat;
        logic [10:0]  adr;
        int           nld;
        int           nrd;
    } exp_t;

    typedef struct {
        logic         wr;
        logic [10:0]  adr;
        logic [W-1:0] d;
        logic [W-1:0] rd_exp;
    } vec_t;

    logic clk_h = 1'b0;
    logic mr_reset_h, req_valid, req_ready, req_write, rsp_valid, rsp_err;
    logic [10:0] req_adr, cra_adr_d_h;
    logic [W-1:0] req_data, rsp_data;
    logic [4:0] slice_sel_h;
    logic diag_load_func_l, diag_read_func_l, ebus_d_oe_h;
    logic [3:0] ebus_d_out_h, ebus_d_in_h;

    int total = 0;
    int bad = 0;
    int n_rsp = 0;
    exp_t exp_q[$];
    int acc_q[$];
    logic [W-1:0] cur_wdata = '0;

    always #5 clk_h = ~clk_h;

    cram_diag_loader dut (
        .clk_h            (clk_h),
        .mr_reset_h       (mr_reset_h),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_adr          (req_adr),
        .req_data         (req_data),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .cra_adr_d_h      (cra_adr_d_h),
        .slice_sel_h      (slice_sel_h),
        .diag_load_func_l (diag_load_func_l),
        .diag_read_func_l (diag_read_func_l),
        .ebus_d_out_h     (ebus_d_out_h),
        .ebus_d_oe_h      (ebus_d_oe_h),
        .ebus_d_in_h      (ebus_d_in_h)
    );

    // CRM board model: unwritten words read back as ~k per slice; corrupt flips slice 5
    logic [W-1:0] mem [0:2047];
    logic wrtn [0:2047];
    logic corrupt;
    logic [W-1:0] rd_word;
    assign rd_word = wrtn[cra_adr_d_h] ? mem[cra_adr_d_h] : PAT_UNW;
    assign ebus_d_in_h = rd_word[4*slice_sel_h +: 4] ^ ((corrupt && slice_sel_h == 5'd5) ? 4'hF : 4'h0);

    always @(posedge clk_h) begin
        if (mr_reset_h) begin
            for (int i = 0; i < 2048; i++) wrtn[i] <= 1'b0;
        end else if (!diag_load_func_l) begin
            mem[cra_adr_d_h][4*slice_sel_h +: 4] <= ebus_d_out_h;
            wrtn[cra_adr_d_h] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic monitor();
        int cyc = 0;
        int lo_ld = 0;
        int lo_rd = 0;
        int nld = 0;
        int nrd = 0;
        int a;
        logic pv = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk_h);
            cyc++;
            if (mr_reset_h) begin
                exp_q.delete();
                acc_q.delete();
                lo_ld = 0;
                lo_rd = 0;
                pv = 1'b0;
                continue;
            end
            if (!diag_read_func_l) begin
                chk("no_strobe_overlap", diag_load_func_l, 1);
                chk("oe_off_in_read", ebus_d_oe_h, 0);
                lo_rd++;
            end else if (lo_rd != 0) begin
                chk("read_strobe_len", lo_rd, 2);
                lo_rd = 0;
                nrd++;
            end
            if (!diag_load_func_l) begin
                chk("oe_on_in_load", ebus_d_oe_h, 1);
                chk("load_nibble", ebus_d_out_h, cur_wdata[4*slice_sel_h +: 4]);
                lo_ld++;
            end else if (lo_ld != 0) begin
                chk("load_strobe_len", lo_ld, 2);
                lo_ld = 0;
                nld++;
            end
            if (req_valid && req_ready) begin
                chk("accept_only_when_idle", acc_q.size(), 0);
                acc_q.push_back(cyc);
                nld = 0;
                nrd = 0;
            end
            if (rsp_valid) begin
                chk("rsp_one_cycle", pv, 0);
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 want no response");
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_latency", cyc - a, e.lat);
                    chk("rsp_adr", cra_adr_d_h, e.adr);
                    chk("load_pulses", nld, e.nld);
                    chk("read_pulses", nrd, e.nrd);
                    n_rsp++;
                end
            end
            pv = rsp_valid;
        end
    endtask

    task automatic send(input logic wr, input logic [10:0] adr, input logic [W-1:0] d,
                        input logic [W-1:0] edata, input logic eerr, input bit hold);
        exp_t e;
        int n = 0;
        @(posedge clk_h);
        #1;
        req_write = wr;
        req_adr = adr;
        req_data = d;
        req_valid = 1'b1;
        while (!req_ready && n < 400) begin
            @(posedge clk_h);
            #1;
            n++;
        end
        if (!req_ready) begin
            chk("send_ready", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        e.data = edata;
        e.err = eerr;
        e.lat = wr ? WLAT : RLAT;
        e.adr = adr;
        e.nld = wr ? NS : 0;
        e.nrd = (!wr || VFY) ? NS : 0;
        exp_q.push_back(e);
        if (wr) cur_wdata = d;
        @(posedge clk_h);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_adr = ~adr;
            req_data = ~d;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk_h);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string nm, input logic rdy);
        chk({nm, "_ready"}, req_ready, rdy);
        chk({nm, "_rsp_valid"}, rsp_valid, 0);
        chk({nm, "_load_l"}, diag_load_func_l, 1);
        chk({nm, "_read_l"}, diag_read_func_l, 1);
        chk({nm, "_oe"}, ebus_d_oe_h, 0);
    endtask

    vec_t vt[7];

    initial begin
        int n;
        int rsp_before;
        mr_reset_h = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_adr = '0;
        req_data = '0;
        corrupt = 1'b0;
        vt[0] = '{1'b1, 11'h055, DA, DA};
        vt[1] = '{1'b0, 11'h055, '0, DA};
        vt[2] = '{1'b1, 11'h7FF, DB, DB};
        vt[3] = '{1'b0, 11'h7FF, '0, DB};
        vt[4] = '{1'b0, 11'o1234, '0, P2};
        vt[5] = '{1'b0, 11'h020, '0, PB};
        vt[6] = '{1'b0, 11'h000, '0, PAT_UNW};
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk_h);
        #1;
        check_idle_outputs("reset", 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_adr", cra_adr_d_h, 0);
        chk("reset_slice", slice_sel_h, 0);
        chk("reset_dout", ebus_d_out_h, 0);
        mr_reset_h = 1'b0;
        repeat (2) @(posedge clk_h);
        #1;
        chk("ready_after_reset", req_ready, 1);

        send(1'b1, 11'h3FF, PB, '0, 1'b0, 1'b0);
        n = 0;
        while (!(!diag_load_func_l && slice_sel_h == 5'd3) && n < 100) begin
            @(posedge clk_h);
            #1;
            n++;
        end
        chk("midwrite_strobe_seen", n < 100, 1);
        mr_reset_h = 1'b1;
        @(posedge clk_h);
        #1;
        check_idle_outputs("midwrite_reset", 0);
        repeat (2) @(posedge clk_h);
        #1;
        mr_reset_h = 1'b0;
        rsp_before = n_rsp;
        repeat (2) @(posedge clk_h);
        #1;
        check_idle_outputs("after_abort", 1);
        repeat (100) @(posedge clk_h);
        chk("no_rsp_after_abort", n_rsp, rsp_before);

        send(1'b1, 11'o1234, P2, VFY ? P2 : '0, 1'b0, 1'b0);
        drain();
        send(1'b0, 11'o0007, '0, PAT_UNW, 1'b0, 1'b0);
        drain();

        send(1'b0, 11'h010, '0, PAT_UNW, 1'b0, 1'b1);
        send(1'b1, 11'h020, PB, VFY ? PB : '0, 1'b0, 1'b0);
        drain();

        foreach (vt[i]) begin
            send(vt[i].wr, vt[i].adr, vt[i].d, (vt[i].wr && !VFY) ? '0 : vt[i].rd_exp, 1'b0, 1'b0);
        end
        drain();

        corrupt = 1'b1;
        send(1'b1, 11'h100, PD, VFY ? PDC : '0, VFY, 1'b0);
        drain();
        send(1'b0, 11'h100, '0, PDC, 1'b0, 1'b0);
        drain();
        corrupt = 1'b0;
        send(1'b1, 11'h100, PD, VFY ? PD : '0, 1'b0, 1'b0);
        drain();
        send(1'b0, 11'h100, '0, PD, 1'b0, 1'b0);
        drain();
        repeat (4) @(posedge clk_h);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end
endmodule
